// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and constants for the iterative multiplier/divider
package multdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int          ITER    = 32;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/multdiv_core.sv
// rtl/multdiv_core.sv - unsigned one-bit-per-cycle shift-add multiply / restoring divide datapath
module multdiv_core
    import multdiv_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  logic               is_mult,
    input  logic               step,
    input  logic [WIDTH-1:0]   a_mag,
    input  logic [WIDTH-1:0]   b_mag,
    output logic [2*WIDTH-1:0] acc,
    output logic               finished
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] shifted;
    logic [2*WIDTH-1:0] addend;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   op_q;
    logic [WIDTH-1:0]   mplier_q;
    logic               mode_mult;
    logic [CW-1:0]      cnt;

    // Divide keeps remainder in the upper half and dividend/quotient bits in the lower half.
    always_comb begin
        shifted  = {acc_q[2*WIDTH-2:0], 1'b0};
        trial    = {1'b0, shifted[2*WIDTH-1:WIDTH]} - {1'b0, op_q};
        addend   = {{WIDTH{1'b0}}, op_q} << cnt;
        acc_next = acc_q;
        if (mode_mult) begin
            if (mplier_q[cnt]) begin
                acc_next = acc_q + addend;
            end
        end else if (!trial[WIDTH]) begin
            acc_next = {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
        end else begin
            acc_next = shifted;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q     <= '0;
            op_q      <= '0;
            mplier_q  <= '0;
            mode_mult <= 1'b0;
            cnt       <= '0;
            finished  <= 1'b0;
        end else if (load) begin
            acc_q     <= is_mult ? '0 : {{WIDTH{1'b0}}, a_mag};
            op_q      <= is_mult ? a_mag : b_mag;
            mplier_q  <= b_mag;
            mode_mult <= is_mult;
            cnt       <= '0;
            finished  <= 1'b0;
        end else if (step && !finished) begin
            acc_q <= acc_next;
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
                finished <= 1'b1;
            end
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - signed 32-bit iterative multiplier/divider with FSM, sign and exception handling
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    state_t             state;
    state_t             state_next;
    logic               start;
    logic               core_step;
    logic               core_finished;
    logic [2*WIDTH-1:0] core_acc;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               sign_q;
    logic               bzero_q;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   res_next;
    logic               exc_next;

    assign start     = ctrl_MULT | ctrl_DIV;
    assign a_mag     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    assign core_step = (state == ST_MULT) || (state == ST_DIV);

    multdiv_core #(.WIDTH(WIDTH)) u_core (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (start),
        .is_mult  (ctrl_MULT),
        .step     (core_step),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .acc      (core_acc),
        .finished (core_finished)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A new start always wins, which is what aborts a running or finishing operation.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ctrl_MULT ? ST_MULT : ST_DIV;
        end else begin
            case (state)
                ST_IDLE: state_next = ST_IDLE;
                ST_MULT: if (core_finished) state_next = ST_DONE;
                ST_DIV:  if (core_finished || bzero_q) state_next = ST_DONE;
                ST_DONE: state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy           = (state != ST_IDLE);
        data_resultRDY = (state == ST_DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sign_q  <= 1'b0;
            bzero_q <= 1'b0;
        end else if (start) begin
            sign_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            bzero_q <= (data_operandB == '0);
        end
    end

    // A positive quotient equal to INT_MIN can only come from INT_MIN / -1.
    always_comb begin
        product  = sign_q ? -core_acc : core_acc;
        quotient = sign_q ? -core_acc[WIDTH-1:0] : core_acc[WIDTH-1:0];
        if (state == ST_MULT) begin
            res_next = product[WIDTH-1:0];
            exc_next = (product[2*WIDTH-1:WIDTH] != {WIDTH{product[WIDTH-1]}});
        end else if (bzero_q) begin
            res_next = '0;
            exc_next = 1'b1;
        end else begin
            res_next = quotient;
            exc_next = !sign_q && (core_acc[WIDTH-1:0] == WIDTH'(INT_MIN));
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (state_next == ST_DONE) begin
            data_result    <= res_next;
            data_exception <= exc_next;
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - table-driven and sequence checks for multdiv_unit
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int tests = 0;
    int failed = 0;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        mult;
        logic        div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          bcnt;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a falling edge; the pulse is sampled at the next rising edge (E0).
    task automatic pulse(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'h1234_5678;
    endtask

    // Watches 40 cycles from the falling edge after E0 (k = 0).
    task automatic observe(output int lat, output int nrdy, output logic [31:0] res,
                           output logic exc, output int bcnt);
        lat  = -1;
        nrdy = 0;
        bcnt = 0;
        res  = '0;
        exc  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy) bcnt++;
            if (data_resultRDY) begin
                nrdy++;
                if (lat < 0) begin
                    lat = k;
                    res = data_result;
                    exc = data_exception;
                end
            end
            @(negedge clock);
        end
    endtask

    int          lat, nrdy, bcnt;
    logic [31:0] res;
    logic        exc;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33, 34};
        vecs[1]  = '{1'b1, 1'b0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1, 33, 34};
        vecs[2]  = '{1'b1, 1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0, 33, 34};
        vecs[3]  = '{1'b1, 1'b0, 32'hFFFF_FFFC,  32'hFFFF_FFFB, 32'd20,        1'b0, 33, 34};
        vecs[4]  = '{1'b1, 1'b0, 32'd0,          32'd5,         32'd0,         1'b0, 33, 34};
        vecs[5]  = '{1'b0, 1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 33, 34};
        vecs[6]  = '{1'b0, 1'b1, 32'd100,        32'd7,         32'd14,        1'b0, 33, 34};
        vecs[7]  = '{1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33, 34};
        vecs[8]  = '{1'b0, 1'b1, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0, 33, 34};
        vecs[9]  = '{1'b0, 1'b1, 32'd7,          32'hFFFF_FF9C, 32'd0,         1'b0, 33, 34};
        vecs[10] = '{1'b0, 1'b1, 32'd5,          32'd0,         32'd0,         1'b1, 1,  2};

        #12;
        chk("reset_result", data_result, 32'd0);
        chk("reset_exc",    {31'd0, data_exception}, 32'd0);
        chk("reset_rdy",    {31'd0, data_resultRDY}, 32'd0);
        chk("reset_busy",   {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 11; i++) begin
            pulse(vecs[i].mult, vecs[i].div, vecs[i].a, vecs[i].b);
            observe(lat, nrdy, res, exc, bcnt);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_rdy_count", i), nrdy, 32'd1);
            chk($sformatf("v%0d_result", i), res, vecs[i].res);
            chk($sformatf("v%0d_exception", i), {31'd0, exc}, {31'd0, vecs[i].exc});
            chk($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].bcnt);
        end

        // Multiply aborted by a divide sampled at E10.
        pulse(1'b1, 1'b0, 32'd3, 32'd4);
        nrdy = 0;
        repeat (9) begin
            if (data_resultRDY) nrdy++;
            @(negedge clock);
        end
        chk("abort_no_early_rdy", nrdy, 32'd0);
        pulse(1'b0, 1'b1, 32'd20, 32'd5);
        observe(lat, nrdy, res, exc, bcnt);
        chk("abort_latency", lat, 32'd33);
        chk("abort_rdy_count", nrdy, 32'd1);
        chk("abort_result", res, 32'd4);

        // Both pulses together: multiply wins.
        pulse(1'b1, 1'b1, 32'd6, 32'd2);
        observe(lat, nrdy, res, exc, bcnt);
        chk("both_latency", lat, 32'd33);
        chk("both_result", res, 32'd12);
        chk("both_rdy_count", nrdy, 32'd1);

        // Restart sampled at the edge that would enter DONE (E33).
        pulse(1'b1, 1'b0, 32'd1, 32'd1);
        repeat (32) @(negedge clock);
        pulse(1'b1, 1'b0, 32'd5, 32'd5);
        observe(lat, nrdy, res, exc, bcnt);
        chk("restart_latency", lat, 32'd33);
        chk("restart_rdy_count", nrdy, 32'd1);
        chk("restart_result", res, 32'd25);

        // Asynchronous reset in the middle of an operation.
        pulse(1'b1, 1'b0, 32'd9, 32'd9);
        repeat (15) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("midreset_result", data_result, 32'd0);
        chk("midreset_exc",    {31'd0, data_exception}, 32'd0);
        chk("midreset_rdy",    {31'd0, data_resultRDY}, 32'd0);
        chk("midreset_busy",   {31'd0, busy}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        observe(lat, nrdy, res, exc, bcnt);
        chk("midreset_no_rdy", nrdy, 32'd0);
        chk("midreset_idle_busy", bcnt, 32'd0);
        pulse(1'b1, 1'b0, 32'd2, 32'd2);
        observe(lat, nrdy, res, exc, bcnt);
        chk("post_reset_latency", lat, 32'd33);
        chk("post_reset_result", res, 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
